// File: rtl/one_pulser.sv
// one_pulser: 2-flop synchronizer, optional debounce (ONE_PULSER_DEBOUNCE_EN), Moore FSM emitting one SP pulse per press.
// Latency 3 edges (3 + DEBOUNCE_CYCLES debounced); no backpressure, SP is a single-cycle strobe.
module one_pulser #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic clkPB,
    input  logic clk,
    input  logic rst,
    output logic SP
);

    // PULSE owns bit 0 alone so SP comes straight off one flop.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        PULSE    = 2'b01,
        WAIT_REL = 2'b10
    } state_t;

    logic   s1_q, s1_d;
    logic   s2_q, s2_d;
    logic   qual;
    state_t state_q, state_d;

    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 || (DEBOUNCE_CYCLES >> CNT_W) != 0) begin : g_cfg_err
        $error("one_pulser: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    always_comb begin
        s1_d = clkPB;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

`ifdef ONE_PULSER_DEBOUNCE_EN
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter runs only while s2 disagrees with the debounced level.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (s2_q != deb_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    assign qual = deb_q;
`else
    assign qual = s2_q;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     state_d = qual ? PULSE : IDLE;
            PULSE:    state_d = qual ? WAIT_REL : IDLE;
            WAIT_REL: state_d = qual ? WAIT_REL : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign SP = state_q[0];

endmodule

// File: tb/tb_one_pulser.sv
// Directed bench for one_pulser: expected SP rise cycles are queued at stimulus time and matched on each observed rise.
`timescale 1ns/100ps
module tb_one_pulser;

`ifdef ONE_PULSER_DEBOUNCE_EN
    localparam int D = 4;
`else
    localparam int D = 0;
`endif
    localparam int LAT     = 3 + D;
    localparam int MIN_HI  = (D < 1) ? 1 : D;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic clk_pb = 1'b0;
    logic sp;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc     = 0;
    logic sp_prev = 1'b0;
    int exp_q[$];

    one_pulser dut (
        .clkPB (clk_pb),
        .clk   (clk),
        .rst   (rst),
        .SP    (sp)
    );

    always #1 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        assert (got === exp) else begin
            err_cnt++;
            $error("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Per-cycle monitor: invariants plus scoreboard pop on every SP rise.
    always @(negedge clk) begin
        chk("sp_matches_pulse_state", {31'b0, sp}, {31'b0, (dut.state_q == 2'b01)});
        chk("sp_not_two_cycles", {31'b0, sp & sp_prev}, 32'd0);
        if (rst) chk("sp_low_in_reset", {31'b0, sp}, 32'd0);
        if (sp && !sp_prev) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("pulse_rise_cycle", 32'(cyc), 32'(exp_q.pop_front()));
            end
        end
        sp_prev = sp;
    end

    task automatic press(input int hi, input int lo);
        if (hi >= MIN_HI) exp_q.push_back(cyc + LAT);
        clk_pb = 1'b1;
        repeat (hi) @(negedge clk);
        clk_pb = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        // Reset held while the button chatters.
        repeat (8) begin
            @(negedge clk);
            clk_pb = ~clk_pb;
            chk("reset_sp", {31'b0, sp}, 32'd0);
            chk("reset_state", {30'b0, dut.state_q}, 32'd0);
        end
        clk_pb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (D + 4) @(negedge clk);

        // Repeated short presses, long hold, single-cycle and back-to-back presses.
        repeat (6) press(3, 2);
        press(20, D + 5);
        press(1, 3);
        press(1, 1);
        press(1, 3);
        press(2, 1);
        press(2, D + 4);
        // Around the debounce threshold (all pulse without debounce).
        press(3, D + 8);
        press(4, D + 8);
        press(10, D + 8);

        // Reset mid-pulse with the button still held through release.
        exp_q.push_back(cyc + LAT);
        clk_pb = 1'b1;
        for (int i = 0; i < 40 && !sp; i++) @(negedge clk);
        chk("pulse_before_reset", {31'b0, sp}, 32'd1);
        #0.3 rst = 1'b1;
        #0.1 chk("async_reset_drop", {31'b0, sp}, 32'd0);
        repeat (3) @(negedge clk);
        chk("sp_held_low_reset", {31'b0, sp}, 32'd0);
        rst = 1'b0;
        exp_q.push_back(cyc + LAT);
        repeat (LAT + 6) @(negedge clk);
        clk_pb = 1'b0;
        repeat (D + 6) @(negedge clk);

        // Every queued pulse must have arrived.
        repeat (20) @(negedge clk);
        chk("pulses_outstanding", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
